// File: rtl/stopwatch_lap_logic.sv
// Parametrised min:sec:hundredths stopwatch with prescaler, overflow policy,
// display hold and a first-word-fall-through FIFO of captured lap times.
module stopwatch_lap_logic #(
  parameter int CLK_DIV   = 1,
  parameter int MAX_MINS  = 99,
  parameter int OVF_WRAP  = 0,
  parameter int LAP_DEPTH = 4
) (
  input  logic                           CLK_100Hz,
  input  logic                           reset_n,
  input  logic                           start_stop,
  input  logic                           hold,
  input  logic                           lap_n,
  input  logic                           lap_rd,
  output logic [6:0]                     stopwatch_unit_mins,
  output logic [5:0]                     stopwatch_unit_secs,
  output logic [6:0]                     stopwatch_unit_decs,
  output logic                           stopwatch_overflow,
  output logic [19:0]                    lap_time,
  output logic                           lap_valid,
  output logic                           lap_full,
  output logic [$clog2(LAP_DEPTH+1)-1:0] lap_count
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int PTR_W = $clog2(LAP_DEPTH);
  localparam int CNT_W = $clog2(LAP_DEPTH + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [6:0]       MAX_M    = 7'(MAX_MINS);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(LAP_DEPTH);

  logic [DIV_W-1:0] div_q, div_d;
  logic [6:0]       mins_q, mins_d;
  logic [5:0]       secs_q, secs_d;
  logic [6:0]       decs_q, decs_d;
  logic             ovf_q, ovf_d;
  logic [6:0]       disp_mins_q, disp_mins_d;
  logic [5:0]       disp_secs_q, disp_secs_d;
  logic [6:0]       disp_decs_q, disp_decs_d;
  logic             lap_prev_q, lap_prev_d;
  logic [19:0]      fifo_q [LAP_DEPTH];
  logic [19:0]      fifo_d [LAP_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic running, tick, at_max;
  logic lap_fall, push, pop, full;

  always_comb begin
    running = !start_stop && !(ovf_q && (OVF_WRAP == 0));
    tick    = running && (div_q == DIV_LAST);
    at_max  = (mins_q == MAX_M) && (secs_q == 6'd59) && (decs_q == 7'd99);
    div_d   = div_q;
    mins_d  = mins_q;
    secs_d  = secs_q;
    decs_d  = decs_q;
    ovf_d   = ovf_q;
    // The prescaler only moves while running, so a stop/resume keeps the phase.
    if (running) begin
      div_d = tick ? '0 : div_q + DIV_W'(1);
    end
    if (tick) begin
      if (at_max) begin
        ovf_d = 1'b1;
        if (OVF_WRAP != 0) begin
          mins_d = '0;
          secs_d = '0;
          decs_d = '0;
        end
      end else if (decs_q != 7'd99) begin
        decs_d = decs_q + 7'd1;
      end else begin
        decs_d = '0;
        if (secs_q != 6'd59) begin
          secs_d = secs_q + 6'd1;
        end else begin
          secs_d = '0;
          mins_d = mins_q + 7'd1;
        end
      end
    end
  end

  always_comb begin
    disp_mins_d = disp_mins_q;
    disp_secs_d = disp_secs_q;
    disp_decs_d = disp_decs_q;
    if (hold) begin
      disp_mins_d = mins_q;
      disp_secs_d = secs_q;
      disp_decs_d = decs_q;
    end
  end

  // Handshake: lap_valid high means lap_time holds the oldest lap; a cycle with
  // lap_rd high while lap_valid is high consumes it at that clock edge.
  always_comb begin
    lap_prev_d = lap_n;
    lap_fall   = lap_prev_q && !lap_n;
    pop        = lap_rd && (cnt_q != '0);
    full       = (cnt_q == CNT_FULL);
    push       = lap_fall && (!full || pop);
    fifo_d     = fifo_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    cnt_d      = cnt_q;
    if (push) begin
      fifo_d[wr_ptr_q] = {mins_q, secs_q, decs_q};
      wr_ptr_d         = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    if (push && !pop) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else if (pop && !push) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge CLK_100Hz or negedge reset_n) begin
    if (!reset_n) begin
      div_q       <= '0;
      mins_q      <= '0;
      secs_q      <= '0;
      decs_q      <= '0;
      ovf_q       <= 1'b0;
      disp_mins_q <= '0;
      disp_secs_q <= '0;
      disp_decs_q <= '0;
      lap_prev_q  <= 1'b1;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      for (int i = 0; i < LAP_DEPTH; i++) begin
        fifo_q[i] <= '0;
      end
    end else begin
      div_q       <= div_d;
      mins_q      <= mins_d;
      secs_q      <= secs_d;
      decs_q      <= decs_d;
      ovf_q       <= ovf_d;
      disp_mins_q <= disp_mins_d;
      disp_secs_q <= disp_secs_d;
      disp_decs_q <= disp_decs_d;
      lap_prev_q  <= lap_prev_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      fifo_q      <= fifo_d;
    end
  end

  assign stopwatch_unit_mins = disp_mins_q;
  assign stopwatch_unit_secs = disp_secs_q;
  assign stopwatch_unit_decs = disp_decs_q;
  assign stopwatch_overflow  = ovf_q;
  assign lap_valid           = (cnt_q != '0);
  assign lap_full            = full;
  assign lap_count           = cnt_q;
  assign lap_time            = lap_valid ? fifo_q[rd_ptr_q] : 20'd0;

endmodule

// File: tb/tb_stopwatch_lap_logic.sv
// Bench for stopwatch_lap_logic: four instances cover prescaler, saturate and
// wrap policies; directed vector table plus hand-written lap/FIFO sequences.
module tb_stopwatch_lap_logic;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n, start_stop, hold, lap_n, lap_rd;

  logic [6:0] a_mins, b_mins, s_mins, w_mins;
  logic [5:0] a_secs, b_secs, s_secs, w_secs;
  logic [6:0] a_decs, b_decs, s_decs, w_decs;
  logic a_ovf, b_ovf, s_ovf, w_ovf;
  logic [19:0] a_lt, b_lt, s_lt, w_lt;
  logic a_lv, b_lv, s_lv, w_lv;
  logic a_lf, b_lf, s_lf, w_lf;
  logic [2:0] a_lc, b_lc, s_lc, w_lc;

  stopwatch_lap_logic #(.CLK_DIV(1), .MAX_MINS(99), .OVF_WRAP(0), .LAP_DEPTH(4)) dut_a (
    .CLK_100Hz(clk), .reset_n(reset_n), .start_stop(start_stop), .hold(hold),
    .lap_n(lap_n), .lap_rd(lap_rd), .stopwatch_unit_mins(a_mins),
    .stopwatch_unit_secs(a_secs), .stopwatch_unit_decs(a_decs),
    .stopwatch_overflow(a_ovf), .lap_time(a_lt), .lap_valid(a_lv),
    .lap_full(a_lf), .lap_count(a_lc));

  stopwatch_lap_logic #(.CLK_DIV(4), .MAX_MINS(99), .OVF_WRAP(0), .LAP_DEPTH(4)) dut_b (
    .CLK_100Hz(clk), .reset_n(reset_n), .start_stop(start_stop), .hold(hold),
    .lap_n(lap_n), .lap_rd(lap_rd), .stopwatch_unit_mins(b_mins),
    .stopwatch_unit_secs(b_secs), .stopwatch_unit_decs(b_decs),
    .stopwatch_overflow(b_ovf), .lap_time(b_lt), .lap_valid(b_lv),
    .lap_full(b_lf), .lap_count(b_lc));

  stopwatch_lap_logic #(.CLK_DIV(1), .MAX_MINS(1), .OVF_WRAP(0), .LAP_DEPTH(4)) dut_s (
    .CLK_100Hz(clk), .reset_n(reset_n), .start_stop(start_stop), .hold(hold),
    .lap_n(lap_n), .lap_rd(lap_rd), .stopwatch_unit_mins(s_mins),
    .stopwatch_unit_secs(s_secs), .stopwatch_unit_decs(s_decs),
    .stopwatch_overflow(s_ovf), .lap_time(s_lt), .lap_valid(s_lv),
    .lap_full(s_lf), .lap_count(s_lc));

  stopwatch_lap_logic #(.CLK_DIV(1), .MAX_MINS(1), .OVF_WRAP(1), .LAP_DEPTH(4)) dut_w (
    .CLK_100Hz(clk), .reset_n(reset_n), .start_stop(start_stop), .hold(hold),
    .lap_n(lap_n), .lap_rd(lap_rd), .stopwatch_unit_mins(w_mins),
    .stopwatch_unit_secs(w_secs), .stopwatch_unit_decs(w_decs),
    .stopwatch_overflow(w_ovf), .lap_time(w_lt), .lap_valid(w_lv),
    .lap_full(w_lf), .lap_count(w_lc));

  // ---------------- scoreboard ----------------
  int errors = 0;
  int checks = 0;
  int ticks  = 0;
  logic [19:0] exp_q[$];

  typedef struct {
    int   n;
    logic ss;
    logic h;
    int   t;
  } vec_t;
  vec_t vecs[9];

  function automatic logic [19:0] t2v(input int n);
    return {7'(n / 6000), 6'((n / 100) % 60), 7'(n % 100)};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Advance n rising edges; ticks tracks the live count of the CLK_DIV=1 instance.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      if (start_stop == 1'b0) ticks++;
      #1;
    end
  endtask

  task automatic do_reset();
    reset_n    = 1'b0;
    start_stop = 1'b1;
    hold       = 1'b1;
    lap_n      = 1'b1;
    lap_rd     = 1'b0;
    step(2);
    reset_n = 1'b1;
    ticks   = 0;
    exp_q.delete();
    step(1);
  endtask

  task automatic lap_pulse();
    lap_n = 1'b0;
    if (exp_q.size() < 4) exp_q.push_back(t2v(ticks));
    step(1);
    lap_n = 1'b1;
    step(1);
  endtask

  // ---------------- test ----------------
  initial begin
    reset_n = 1'b0; start_stop = 1'b1; hold = 1'b1; lap_n = 1'b1; lap_rd = 1'b0;

    vecs[0] = '{3,    1'b1, 1'b1, 0};
    vecs[1] = '{6000, 1'b0, 1'b1, 5999};
    vecs[2] = '{1,    1'b1, 1'b1, 6000};
    vecs[3] = '{50,   1'b1, 1'b1, 6000};
    vecs[4] = '{51,   1'b0, 1'b1, 6050};
    vecs[5] = '{100,  1'b0, 1'b0, 6050};
    vecs[6] = '{1,    1'b0, 1'b1, 6151};
    vecs[7] = '{1,    1'b1, 1'b1, 6152};
    vecs[8] = '{5,    1'b1, 1'b0, 6152};

    // reset state of every instance
    do_reset();
    chk("rst_a_disp", {a_mins, a_secs, a_decs}, 0);
    chk("rst_a_ovf", a_ovf, 0);
    chk("rst_a_lt", a_lt, 0);
    chk("rst_a_lv", a_lv, 0);
    chk("rst_a_lf", a_lf, 0);
    chk("rst_a_lc", a_lc, 0);
    chk("rst_b", {b_mins, b_secs, b_decs, b_ovf, b_lt, b_lv, b_lf, b_lc}, 0);
    chk("rst_s", {s_mins, s_secs, s_decs, s_ovf, s_lt, s_lv, s_lf, s_lc}, 0);
    chk("rst_w", {w_mins, w_secs, w_decs, w_ovf, w_lt, w_lv, w_lf, w_lc}, 0);

    // counting, stop, hold freeze/release (CLK_DIV=1)
    for (int i = 0; i < 9; i++) begin
      start_stop = vecs[i].ss;
      hold       = vecs[i].h;
      step(vecs[i].n);
      chk($sformatf("vec%0d_disp", i), {a_mins, a_secs, a_decs}, t2v(vecs[i].t));
      chk($sformatf("vec%0d_ovf", i), a_ovf, 0);
    end

    // prescaler CLK_DIV=4, phase preserved across stop
    do_reset();
    start_stop = 1'b0; step(400);
    start_stop = 1'b1; step(1);
    chk("div4_400", {b_mins, b_secs, b_decs}, t2v(100));
    start_stop = 1'b0; step(2);
    start_stop = 1'b1; step(10);
    chk("div4_part", {b_mins, b_secs, b_decs}, t2v(100));
    start_stop = 1'b0; step(1);
    start_stop = 1'b1; step(1);
    chk("div4_3rd", {b_mins, b_secs, b_decs}, t2v(100));
    start_stop = 1'b0; step(1);
    start_stop = 1'b1; step(1);
    chk("div4_4th", {b_mins, b_secs, b_decs}, t2v(101));

    // overflow: saturate vs wrap with MAX_MINS=1
    do_reset();
    start_stop = 1'b0; step(11999);
    start_stop = 1'b1; step(1);
    chk("sat_top", {s_mins, s_secs, s_decs}, t2v(11999));
    chk("wrap_top", {w_mins, w_secs, w_decs}, t2v(11999));
    chk("sat_ovf0", s_ovf, 0);
    start_stop = 1'b0; step(1);
    chk("sat_ovf1", s_ovf, 1);
    chk("wrap_ovf1", w_ovf, 1);
    step(1);
    chk("sat_hold1", {s_mins, s_secs, s_decs}, t2v(11999));
    chk("wrap_zero", {w_mins, w_secs, w_decs}, 0);
    step(1);
    chk("wrap_one", {w_mins, w_secs, w_decs}, t2v(1));
    step(98);
    chk("wrap_run", {w_mins, w_secs, w_decs}, t2v(99));
    chk("wrap_sticky", w_ovf, 1);
    chk("sat_hold2", {s_mins, s_secs, s_decs}, t2v(11999));
    chk("sat_sticky", s_ovf, 1);

    // lap FIFO: capture while stopped, fill, drop 5th, drain, empty pop
    do_reset();
    step(5);
    lap_pulse();
    start_stop = 1'b0; step(13);
    lap_pulse();
    step(250);
    lap_pulse();
    lap_pulse();
    chk("lap4_count", a_lc, 4);
    chk("lap4_full", a_lf, 1);
    step(77);
    lap_pulse();
    chk("lap5_count", a_lc, 4);
    chk("lap5_valid", a_lv, 1);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("pop%0d_time", i), a_lt, exp_q[0]);
      void'(exp_q.pop_front());
      lap_rd = 1'b1; step(1); lap_rd = 1'b0;
    end
    chk("drain_valid", a_lv, 0);
    chk("drain_count", a_lc, 0);
    chk("drain_full", a_lf, 0);
    chk("drain_time", a_lt, 0);
    lap_rd = 1'b1; step(1); lap_rd = 1'b0;
    chk("empty_pop_count", a_lc, 0);
    chk("empty_pop_valid", a_lv, 0);

    // capture + pop on empty: push only
    lap_n = 1'b0; lap_rd = 1'b1;
    exp_q.push_back(t2v(ticks));
    step(1);
    lap_n = 1'b1; lap_rd = 1'b0;
    step(1);
    chk("cp_empty_count", a_lc, 1);
    chk("cp_empty_time", a_lt, exp_q[0]);
    for (int i = 0; i < 3; i++) begin
      step(7);
      lap_pulse();
    end
    chk("refill_full", a_lf, 1);

    // capture + pop when full: head advances, count stays
    lap_n = 1'b0; lap_rd = 1'b1;
    void'(exp_q.pop_front());
    exp_q.push_back(t2v(ticks));
    step(1);
    lap_n = 1'b1; lap_rd = 1'b0;
    chk("cp_full_count", a_lc, 4);
    chk("cp_full_full", a_lf, 1);
    step(1);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("cp_order%0d", i), a_lt, exp_q[0]);
      if (i < 3) begin
        void'(exp_q.pop_front());
        lap_rd = 1'b1; step(1); lap_rd = 1'b0;
      end
    end

    // asynchronous reset mid-run, checked before any clock edge
    step(3);
    reset_n = 1'b0;
    #2;
    chk("arst_disp", {a_mins, a_secs, a_decs}, 0);
    chk("arst_ovf", a_ovf, 0);
    chk("arst_valid", a_lv, 0);
    chk("arst_count", a_lc, 0);
    chk("arst_time", a_lt, 0);
    step(2);
    reset_n = 1'b1;

    // ---------------- final report ----------------
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/stopwatch_lap_logic.md
Name: stopwatch_lap_logic

Overview:
Parametrised stopwatch counter producing minutes/seconds/hundredths, successor to the fixed 100 Hz stopwatch logic. Adds a configurable clock prescaler, a configurable minute limit, a selectable overflow policy (saturate or wrap), and a FIFO of captured lap times readable by the display/readout block. Sits between the input debouncers and the 7-segment/readout drivers.

Parameters:
CLK_DIV, 1, CLK_100Hz cycles per hundredth-second tick (>=1).
MAX_MINS, 99, highest minute value (1..127).
OVF_WRAP, 0, 0 = stop and saturate at MAX_MINS:59:99; 1 = wrap to 0:00:00 and keep counting.
LAP_DEPTH, 4, lap FIFO entries (power of 2, >=2).

Ports:
CLK_100Hz  in  1  single clock, rising edge
reset_n  in  1  asynchronous reset, active-low
start_stop  in  1  level, active-low: low = run, high = stopped
hold  in  1  level, active-low: freezes displayed outputs, internal count continues
lap_n  in  1  active-low; falling edge captures a lap
lap_rd  in  1  active-high pop of lap FIFO head
stopwatch_unit_mins  out  7  displayed minutes, binary
stopwatch_unit_secs  out  6  displayed seconds 0..59
stopwatch_unit_decs  out  7  displayed hundredths 0..99
stopwatch_overflow  out  1  sticky overflow flag
lap_time  out  20  FIFO head {mins[6:0],secs[5:0],decs[6:0]}
lap_valid  out  1  FIFO non-empty
lap_full  out  1  FIFO full
lap_count  out  $clog2(LAP_DEPTH+1)  entries held

Behaviour:
- Reset (async, reset_n low): live counters, prescaler, all outputs, overflow, FIFO pointers, lap_n edge register (set to 1) -> 0/empty. Takes effect immediately, mid-count included; first tick after release needs CLK_DIV running cycles.
- Running = start_stop==0 and not (overflow and OVF_WRAP==0). Inputs are synchronous to CLK_100Hz (debounced upstream).
- Prescaler div_cnt 0..CLK_DIV-1 advances only while running; tick when div_cnt==CLK_DIV-1 (then div_cnt->0). Stopping holds div_cnt (no reset); resume continues from it.
- On tick: decs+1; decs 99->0 carries secs; secs 59->0 carries mins; at MAX_MINS:59:99 tick: OVF_WRAP=0 -> counters stay MAX_MINS:59:99, overflow<=1, counting halts until reset; OVF_WRAP=1 -> counters ->0:00:00, overflow<=1 (sticky), counting continues.
- Display outputs registered: hold high -> outputs equal live count one cycle after each update (1-cycle latency). hold low -> outputs frozen at value present when hold first sampled low; on hold release, outputs track live count next cycle. stopwatch_overflow never frozen.
- Lap capture: lap_prev registered; capture when lap_prev==1 and lap_n==0. Captured value = live count before any tick in same cycle. Capture allowed while stopped.
- FIFO first-word-fall-through: lap_time valid whenever lap_valid=1; lap_rd with lap_valid=1 pops at clock edge; lap_rd when empty ignored (no pointer change). lap_time = 0 when empty.
- Full: capture when full and no pop -> new lap dropped, FIFO unchanged. Capture and pop same cycle when full -> both occur, count unchanged. Capture and pop when empty -> push only.
- lap_count/lap_valid/lap_full update same edge as push/pop.

Test Plan:
- CLK_DIV=1, reset then start_stop=0 for 6000 cycles -> outputs 1:00:00 one cycle later; start_stop=1 for 50 cycles -> unchanged.
- CLK_DIV=4, run 400 cycles -> 0:01:00; stop after 2 cycles into a tick period, resume -> next tick after 2 more running cycles.
- MAX_MINS=1, OVF_WRAP=0, run 12000 cycles -> 1:59:99, overflow=1, further cycles hold; OVF_WRAP=1 same stimulus +1 cycle -> 0:00:00 / 0:00:01 counting, overflow=1 sticky.
- Run to 0:00:50, hold=0 for 100 cycles -> outputs stay 0:00:50(ish, captured value) while live reaches 0:01:50; hold=1 -> outputs show live value next cycle.
- LAP_DEPTH=4: 5 lap_n falling edges at known times -> lap_count=4, lap_full=1, 5th dropped; pop 4 -> times in capture order, lap_valid=0; pop on empty -> no change.
- Capture+pop same cycle when full -> count stays 4, head advances; assert reset_n mid-run -> all outputs 0, FIFO empty immediately.
